// File: rtl/switch_port_pkg.sv
// Shared types and address helpers for the switch_port memory-mapped input responder.
package switch_port_pkg;

  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} deb_state_t;

  localparam int STAT_NEW = 0;
  localparam int STAT_OVR = 1;

  // The top of the address space is shared with the display register at N-2.
  function automatic int data_addr(input int word_w, input int op_w);
    return (1 << (word_w - op_w)) - 1;
  endfunction

  function automatic int stat_addr(input int word_w, input int op_w);
    return (1 << (word_w - op_w)) - 3;
  endfunction

endpackage

// File: rtl/switch_port_if.sv
// Processor data-bus signals seen by a memory-mapped responder.
interface switch_port_if #(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3
) ();

  logic [WORD_W-OP_W-1:0] Daddress;
  logic                   RE;
  logic                   WE;
  logic [WORD_W-1:0]      Wdata;
  logic [WORD_W-1:0]      Sdata;

  modport master (output Daddress, RE, WE, Wdata, input Sdata);
  modport slave  (input Daddress, RE, WE, Wdata, output Sdata);

endinterface

// File: rtl/switch_port_sync2.sv
// Two-flop synchroniser bringing the raw switch word into the clock domain.
module switch_port_sync2 #(
  parameter int WORD_W = 8
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic [WORD_W-1:0] i_async,
  output logic [WORD_W-1:0] o_sync
);

  logic [WORD_W-1:0] r_sync1;
  logic [WORD_W-1:0] r_sync2;

  // NOTE: non-blocking assignments keep this a two-stage chain; blocking ones would collapse it to one flop.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
    end
  end

  assign o_sync = r_sync2;

endmodule

// File: rtl/switch_port.sv
// Debounced switch input register with DATA and STATUS (new/overrun) registers on the data bus.
module switch_port
  import switch_port_pkg::*;
#(
  parameter int WORD_W     = 8,
  parameter int OP_W       = 3,
  parameter int DEB_CYCLES = 16
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic [WORD_W-1:0] switches,
  switch_port_if.slave      bus
);

  localparam int AW    = WORD_W - OP_W;
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  localparam logic [AW-1:0]    DATA_ADDR = AW'(data_addr(WORD_W, OP_W));
  localparam logic [AW-1:0]    STAT_ADDR = AW'(stat_addr(WORD_W, OP_W));
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEB_CYCLES - 1);

  logic [WORD_W-1:0] w_sync;

  deb_state_t        r_state;
  logic [WORD_W-1:0] r_cand;
  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_stable;
  logic [WORD_W-1:0] r_data;
  logic              r_new;
  logic              r_ovr;

  deb_state_t        w_state_nxt;
  logic [WORD_W-1:0] w_cand_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_commit;

  logic              w_rd_data;
  logic              w_wr_stat;
  logic              w_clr_new;
  logic              w_clr_ovr;
  logic              w_new_nxt;
  logic              w_ovr_nxt;

  switch_port_sync2 #(.WORD_W(WORD_W)) u_sync (
    .clock   (clock),
    .n_reset (n_reset),
    .i_async (switches),
    .o_sync  (w_sync)
  );

  // NOTE: every combinational output gets a default first so no branch can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sync != r_stable) begin
          w_cand_nxt  = w_sync;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = COUNT;
        end
      end
      COUNT: begin
        // Returning to the committed value is a glitch and outranks a restart.
        if (w_sync == r_stable) begin
          w_state_nxt = IDLE;
        end else if (w_sync != r_cand) begin
          w_cand_nxt = w_sync;
          w_cnt_nxt  = CNT_W'(1);
        end else if (r_cnt == CNT_LAST) begin
          w_commit    = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
    endcase
  end

  // A commit coinciding with a clear of new counts as consumed-then-refilled, so no overrun.
  always_comb begin
    w_rd_data = bus.RE && (bus.Daddress == DATA_ADDR);
    w_wr_stat = bus.WE && (bus.Daddress == STAT_ADDR);
    w_clr_new = w_rd_data || (w_wr_stat && bus.Wdata[STAT_NEW]);
    w_clr_ovr = w_wr_stat && bus.Wdata[STAT_OVR];
    w_new_nxt = w_commit || (r_new && !w_clr_new);
    w_ovr_nxt = (w_commit && r_new && !w_clr_new) || (r_ovr && !w_clr_ovr);
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state  <= IDLE;
      r_cand   <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
      r_data   <= '0;
      r_new    <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_commit) begin
        r_stable <= r_cand;
        r_data   <= r_cand;
      end
      r_new <= w_new_nxt;
      r_ovr <= w_ovr_nxt;
    end
  end

  always_comb begin
    bus.Sdata = '0;
    if (bus.Daddress == DATA_ADDR) begin
      bus.Sdata = r_data;
    end else if (bus.Daddress == STAT_ADDR) begin
      bus.Sdata[STAT_NEW] = r_new;
      bus.Sdata[STAT_OVR] = r_ovr;
    end
  end

endmodule
